// File: rtl/btb_update_ctrl_if.sv
// Bundle between EX branch resolution, the BTB storage port and the update controller.
// The master side is the surrounding pipeline/storage; the slave side is btb_update_ctrl.
interface btb_update_ctrl_if #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 25
);
    logic               flush_req;
    logic               upd_valid;
    logic               upd_ready;
    logic [31:0]        upd_pc;
    logic               upd_taken;
    logic [31:0]        upd_target;
    logic [TAG_W-1:0]   rd_tag;
    logic [1:0]         rd_cnt;
    logic               tbl_we;
    logic [INDEX_W-1:0] tbl_index;
    logic [TAG_W-1:0]   tbl_tag;
    logic [31:0]        tbl_target;
    logic [1:0]         tbl_cnt;
    logic               busy;

    modport master (
        output flush_req, upd_valid, upd_pc, upd_taken, upd_target, rd_tag, rd_cnt,
        input  upd_ready, tbl_we, tbl_index, tbl_tag, tbl_target, tbl_cnt, busy
    );

    modport slave (
        input  flush_req, upd_valid, upd_pc, upd_taken, upd_target, rd_tag, rd_cnt,
        output upd_ready, tbl_we, tbl_index, tbl_tag, tbl_target, tbl_cnt, busy
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: invalidate sweep after reset/flush, then drains an in-order queue
// of EX branch resolutions as read-modify-writes on the single table write port.
module btb_update_ctrl #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 32 - INDEX_W - 2,
    parameter int QDEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    btb_update_ctrl_if.slave  bus
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0]   Q_FULL   = CNT_W'(QDEPTH);
    localparam logic [INDEX_W-1:0] IDX_LAST = '1;

    logic [0:0]         state_reg, state_next;
    logic [INDEX_W-1:0] sweep_idx_reg, sweep_idx_next;
    logic [PTR_W-1:0]   head_reg, head_next;
    logic [PTR_W-1:0]   tail_reg, tail_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [31:0] q_pc_reg     [QDEPTH];
    logic        q_taken_reg  [QDEPTH];
    logic [31:0] q_target_reg [QDEPTH];

    logic               in_run;
    logic               push;
    logic               pop;
    logic [31:0]        head_pc;
    logic               head_taken;
    logic [31:0]        head_target;
    logic [INDEX_W-1:0] head_index;
    logic [TAG_W-1:0]   head_tag;
    logic               head_hit;
    logic               head_never;
    logic [1:0]         cnt_inc;
    logic [1:0]         cnt_dec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_run      = !reset && (state_reg == ST_RUN);
    assign pop         = in_run && (count_reg != '0);
    // A flush in the same cycle discards the handshake even though ready was shown.
    assign push        = in_run && bus.upd_valid && bus.upd_ready && !bus.flush_req;

    assign head_pc     = q_pc_reg[head_reg];
    assign head_taken  = q_taken_reg[head_reg];
    assign head_target = q_target_reg[head_reg];
    assign head_index  = head_pc[INDEX_W+1:2];
    assign head_tag    = head_pc[31:INDEX_W+2];
    assign head_hit    = (bus.rd_tag == head_tag);
    assign head_never  = &head_tag;
    assign cnt_inc     = (bus.rd_cnt == 2'b11) ? 2'b11 : bus.rd_cnt + 2'b01;
    assign cnt_dec     = (bus.rd_cnt == 2'b00) ? 2'b00 : bus.rd_cnt - 2'b01;

    always_comb begin
        bus.tbl_we     = 1'b0;
        bus.tbl_index  = '0;
        bus.tbl_tag    = '0;
        bus.tbl_target = '0;
        bus.tbl_cnt    = '0;
        bus.busy       = reset || (state_reg == ST_SWEEP);
        bus.upd_ready  = in_run && (count_reg < Q_FULL);
        if (!reset) begin
            if (state_reg == ST_SWEEP) begin
                // All-ones tag can never match a real PC, so swept entries never hit.
                bus.tbl_we    = 1'b1;
                bus.tbl_index = sweep_idx_reg;
                bus.tbl_tag   = '1;
                bus.tbl_cnt   = 2'b01;
            end else if (pop) begin
                bus.tbl_index = head_index;
                if (!bus.flush_req && !head_never) begin
                    if (head_hit) begin
                        bus.tbl_we     = 1'b1;
                        bus.tbl_tag    = head_tag;
                        bus.tbl_target = head_target;
                        bus.tbl_cnt    = head_taken ? cnt_inc : cnt_dec;
                    end else if (head_taken) begin
                        bus.tbl_we     = 1'b1;
                        bus.tbl_tag    = head_tag;
                        bus.tbl_target = head_target;
                        bus.tbl_cnt    = 2'b10;
                    end
                end
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        head_next      = head_reg;
        tail_next      = tail_reg;
        count_next     = count_reg;
        if (bus.flush_req) begin
            state_next     = ST_SWEEP;
            sweep_idx_next = '0;
            head_next      = '0;
            tail_next      = '0;
            count_next     = '0;
        end else if (state_reg == ST_SWEEP) begin
            sweep_idx_next = sweep_idx_reg + 1'b1;
            if (sweep_idx_reg == IDX_LAST) begin
                state_next = ST_RUN;
            end
        end else begin
            if (push) begin
                tail_next = ptr_inc(tail_reg);
            end
            if (pop) begin
                head_next = ptr_inc(head_reg);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_SWEEP;
            sweep_idx_reg <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_reg[tail_reg]     <= bus.upd_pc;
            q_taken_reg[tail_reg]  <= bus.upd_taken;
            q_target_reg[tail_reg] <= bus.upd_target;
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl: a table-level BTB model predicts every write at
// acceptance time into a scoreboard queue; a negedge monitor checks what the DUT emits.
module tb_btb_update_ctrl;
    localparam int INDEX_W = 5;
    localparam int TAG_W   = 25;
    localparam int QDEPTH  = 2;
    localparam int DEPTH   = 32;
    localparam logic [TAG_W-1:0] TAG_ONES = '1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    btb_update_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus();

    btb_update_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Table storage the DUT reads asynchronously and writes at the clock edge.
    logic [TAG_W-1:0] st_tag [DEPTH];
    logic [1:0]       st_cnt [DEPTH];
    logic [31:0]      st_tgt [DEPTH];
    assign bus.rd_tag = st_tag[bus.tbl_index];
    assign bus.rd_cnt = st_cnt[bus.tbl_index];
    always @(posedge clk) begin
        if (bus.tbl_we) begin
            st_tag[bus.tbl_index] <= bus.tbl_tag;
            st_cnt[bus.tbl_index] <= bus.tbl_cnt;
            st_tgt[bus.tbl_index] <= bus.tbl_target;
        end
    end

    typedef struct packed {
        logic [4:0]  idx;
        logic [24:0] tag;
        logic [31:0] tgt;
        logic [1:0]  cnt;
    } wr_t;

    wr_t              exp_q[$];
    logic [TAG_W-1:0] ref_tag [DEPTH];
    int               ref_cnt [DEPTH];
    int               n_vec = 0;
    int               n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // After any sweep every entry holds the never-hit tag with a weakly-not-taken counter.
    function automatic void ref_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_tag[i] = TAG_ONES;
            ref_cnt[i] = 1;
        end
        exp_q.delete();
    endfunction

    function automatic void ref_accept(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int               i;
        int               c;
        logic [TAG_W-1:0] t;
        wr_t              w;
        i = int'(pc[6:2]);
        t = pc[31:7];
        if (t == TAG_ONES) return;
        if (ref_tag[i] == t) begin
            if (taken) c = (ref_cnt[i] >= 3) ? 3 : ref_cnt[i] + 1;
            else       c = (ref_cnt[i] <= 0) ? 0 : ref_cnt[i] - 1;
        end else if (taken) begin
            c = 2;
        end else begin
            return;
        end
        ref_tag[i] = t;
        ref_cnt[i] = c;
        w.idx = 5'(i);
        w.tag = t;
        w.tgt = tgt;
        w.cnt = 2'(c);
        exp_q.push_back(w);
    endfunction

    // Monitor: independent sweep counter and queue occupancy derived from the accept rules.
    int sweeping = 1;
    int sw       = 0;
    int occ      = 0;
    always @(negedge clk) begin
        wr_t w;
        int  push;
        if (reset) begin
            chk("reset_ctl", {bus.tbl_we, bus.busy, bus.upd_ready}, 3'b010);
            chk("reset_bus", {bus.tbl_index, bus.tbl_tag, bus.tbl_target, bus.tbl_cnt}, 64'd0);
            sweeping = 1;
            sw       = 0;
            occ      = 0;
        end else if (sweeping != 0) begin
            chk("sweep_ctl", {bus.tbl_we, bus.busy, bus.upd_ready}, 3'b110);
            chk("sweep_bus", {bus.tbl_index, bus.tbl_tag, bus.tbl_target, bus.tbl_cnt},
                {5'(sw), TAG_ONES, 32'd0, 2'b01});
            if (bus.flush_req)     sw = 0;
            else if (sw == DEPTH-1) begin sweeping = 0; sw = 0; end
            else                   sw++;
        end else begin
            chk("run_busy", bus.busy, 1'b0);
            chk("upd_ready", bus.upd_ready, (occ < QDEPTH) ? 1'b1 : 1'b0);
            if (bus.flush_req) begin
                chk("flush_no_write", bus.tbl_we, 1'b0);
            end else if (bus.tbl_we) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", bus.tbl_we, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    chk("table_write", {bus.tbl_index, bus.tbl_tag, bus.tbl_target, bus.tbl_cnt}, w);
                    $display("wr idx=%0d tag=%0h tgt=%0h cnt=%0d", w.idx, w.tag, w.tgt, w.cnt);
                end
            end else if (occ == 0) begin
                chk("idle_bus", {bus.tbl_index, bus.tbl_tag, bus.tbl_target, bus.tbl_cnt}, 64'd0);
            end
            push = (bus.upd_valid && occ < QDEPTH && !bus.flush_req) ? 1 : 0;
            if (bus.flush_req) begin
                sweeping = 1;
                sw       = 0;
                occ      = 0;
            end else begin
                occ = occ + push - ((occ > 0) ? 1 : 0);
            end
        end
    end

    // One clock of stimulus; the expected write is queued once the handshake is seen.
    task automatic step(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic fl, input logic rs, output logic acc);
        @(posedge clk);
        #1;
        reset          = rs;
        bus.flush_req  = fl;
        bus.upd_valid  = v;
        bus.upd_pc     = pc;
        bus.upd_taken  = tk;
        bus.upd_target = tgt;
        @(negedge clk);
        #1;
        acc = 1'b0;
        if (rs || fl) begin
            ref_clear();
        end else if (v && bus.upd_ready) begin
            acc = 1'b1;
            ref_accept(pc, tk, tgt);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) step(1'b1, pc, tk, tgt, 1'b0, 1'b0, acc);
        chk("handshake", acc, 1'b1);
    endtask

    function automatic logic [31:0] rnd_pc();
        int          r;
        logic [24:0] t;
        logic [4:0]  i;
        r = $urandom_range(0, 9);
        t = (r < 4) ? 25'd0 : (r < 7) ? 25'd1 : (r == 7) ? 25'd2 : (r == 8) ? TAG_ONES : 25'($urandom);
        r = $urandom_range(0, 3);
        i = (r == 0) ? 5'd0 : (r == 1) ? 5'd1 : (r == 2) ? 5'd16 : 5'($urandom);
        return {t, i, 2'b00};
    endfunction

    task automatic rand_run(input int n, input int flush_den);
        logic acc;
        for (int k = 0; k < n; k++) begin
            step(($urandom_range(0, 3) != 0), rnd_pc(), ($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, flush_den - 1) == 0), 1'b0, acc);
        end
    endtask

    initial begin
        logic acc;
        bus.flush_req  = 1'b0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        ref_clear();

        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
        idle(34);

        // Allocate, promote, saturate; then a miss not-taken and demotion to zero.
        send(32'h0000_0040, 1'b1, 32'h100);
        send(32'h0000_0040, 1'b1, 32'h100);
        send(32'h0000_0040, 1'b1, 32'h100);
        send(32'h0000_0080, 1'b0, 32'h200);
        for (int k = 0; k < 4; k++) send(32'h0000_0040, 1'b0, 32'h100);
        idle(3);

        // Back-to-back offers, then a flush with an entry still queued.
        for (int k = 0; k < 4; k++) step(1'b1, rnd_pc(), 1'b1, $urandom, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0000_0044, 1'b1, 32'h300, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0000_0048, 1'b1, 32'h304, 1'b1, 1'b0, acc);
        idle(20);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, acc);
        idle(34);

        rand_run(400, 50);

        rand_run(10, 1000);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
        idle(34);

        rand_run(400, 60);
        idle(40);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
